// File: rtl/ip_sdram_arbiter_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM state encoding and port ids.
package ip_sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    localparam logic PORT_VDP  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/ip_sdram_arbiter_pick.sv
// Winner select between the VDP and host ports. Round-robin priority is built
// only when IP_SDRAM_ARBITER_ROUND_ROBIN_EN is defined; otherwise port 0 always wins.
module ip_sdram_arbiter_pick
    import ip_sdram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       n_reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       winner
);

`ifdef IP_SDRAM_ARBITER_ROUND_ROBIN_EN
    logic last_q;
    logic last_d;

    always_comb begin
        if (req[0] && req[1]) begin
            winner = ~last_q;
        end else if (req[0]) begin
            winner = PORT_VDP;
        end else begin
            winner = PORT_HOST;
        end
        last_d = last_q;
        if (grant_en) begin
            last_d = winner;
        end
    end

    // Reset to host so the VDP port wins the first contested grant.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            last_q <= PORT_HOST;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_pick;
    assign unused_pick = ^{clk, n_reset, grant_en, req[1]};

    assign winner = req[0] ? PORT_VDP : PORT_HOST;
`endif

endmodule

// File: rtl/ip_sdram_arbiter.sv
// Serialises VDP (port 0) and host (port 1) accesses onto a single ip_sdram controller.
// Optional round-robin arbitration: define IP_SDRAM_ARBITER_ROUND_ROBIN_EN.
module ip_sdram_arbiter
    import ip_sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [7:0]        p0_wdata,
    output logic              p0_ack,
    output logic [15:0]       p0_rdata,
    output logic              p0_rdata_en,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [7:0]        p1_wdata,
    output logic              p1_ack,
    output logic [15:0]       p1_rdata,
    output logic              p1_rdata_en,
    output logic              sdram_rd_n,
    output logic              sdram_wr_n,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [7:0]        sdram_wdata,
    input  logic              sdram_busy,
    input  logic [15:0]       sdram_rdata,
    input  logic              sdram_rdata_en
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                wr_q, wr_d;
    logic                got_q, got_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          rdata_en_q, rdata_en_d;
    logic [1:0][15:0]    rdata_q, rdata_d;

    logic [1:0]          req;
    logic                winner;
    logic                grant;
    logic                rd_take;

    assign req = {p1_req, p0_req};

    ip_sdram_arbiter_pick u_pick (
        .clk      (clk),
        .n_reset  (n_reset),
        .req      (req),
        .grant_en (grant),
        .winner   (winner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        got_d      = got_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        ack_d      = '0;
        rdata_en_d = '0;
        rdata_d    = rdata_q;
        grant      = 1'b0;

        // Read data is only meaningful once our own read command has gone out.
        rd_take = sdram_rdata_en && !wr_q &&
                  (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE);
        if (rd_take) begin
            rdata_d[owner_q]    = sdram_rdata;
            rdata_en_d[owner_q] = 1'b1;
            got_d               = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!sdram_busy && (req != 2'b00)) begin
                    grant         = 1'b1;
                    owner_d       = winner;
                    wr_d          = winner ? p1_wr : p0_wr;
                    addr_d        = winner ? p1_address : p0_address;
                    wdata_d       = winner ? p1_wdata : p0_wdata;
                    got_d         = 1'b0;
                    rd_n_d        = wr_d;
                    wr_n_d        = ~wr_d;
                    ack_d[winner] = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (sdram_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!sdram_busy && (wr_q || got_q || rd_take)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= PORT_VDP;
            wr_q       <= 1'b0;
            got_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            ack_q      <= '0;
            rdata_en_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            got_q      <= got_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            ack_q      <= ack_d;
            rdata_en_q <= rdata_en_d;
            rdata_q    <= rdata_d;
        end
    end

    assign sdram_rd_n    = rd_n_q;
    assign sdram_wr_n    = wr_n_q;
    assign sdram_address = addr_q;
    assign sdram_wdata   = wdata_q;
    assign p0_ack        = ack_q[0];
    assign p1_ack        = ack_q[1];
    assign p0_rdata_en   = rdata_en_q[0];
    assign p1_rdata_en   = rdata_en_q[1];
    assign p0_rdata      = rdata_q[0];
    assign p1_rdata      = rdata_q[1];

endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// Self-checking bench for ip_sdram_arbiter: vector table, directed corner cases,
// and randomized traffic against a transaction-level reference.
module tb_ip_sdram_arbiter;

`ifdef IP_SDRAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset;
    logic        p0_req, p0_wr, p1_req, p1_wr;
    logic [16:0] p0_address, p1_address;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, p0_rdata_en, p1_rdata_en;
    logic [15:0] p0_rdata, p1_rdata;
    logic        sdram_rd_n, sdram_wr_n;
    logic [16:0] sdram_address;
    logic [7:0]  sdram_wdata;
    logic        sdram_busy, sdram_rdata_en;
    logic [15:0] sdram_rdata;

    // Either a scripted ip_sdram (man_*) or the auto-responding model (mdl_*).
    logic        mdl_auto = 1'b0;
    logic        man_busy, man_rden;
    logic [15:0] man_rdata;
    logic        mdl_busy = 1'b0, mdl_rden = 1'b0;
    logic [15:0] mdl_rdata = '0;
    logic        mdl_fixed = 1'b0;
    logic [15:0] mdl_data = '0;
    int          mdl_blen = 2;

    assign sdram_busy     = mdl_auto ? mdl_busy  : man_busy;
    assign sdram_rdata_en = mdl_auto ? mdl_rden  : man_rden;
    assign sdram_rdata    = mdl_auto ? mdl_rdata : man_rdata;

    always #5 clk = ~clk;

    ip_sdram_arbiter #(.ADDR_W(17)) dut (
        .clk(clk), .n_reset(n_reset),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_address(p0_address), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rdata_en(p0_rdata_en),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_address(p1_address), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rdata_en(p1_rdata_en),
        .sdram_rd_n(sdram_rd_n), .sdram_wr_n(sdram_wr_n), .sdram_address(sdram_address),
        .sdram_wdata(sdram_wdata), .sdram_busy(sdram_busy), .sdram_rdata(sdram_rdata),
        .sdram_rdata_en(sdram_rdata_en)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit ref_last;

    function automatic logic [15:0] fn(input logic [16:0] a);
        return {a[7:0], a[15:8]} ^ {15'd0, a[16]} ^ 16'hC3A5;
    endfunction

    // ip_sdram stand-in: busy for blen+1 cycles after a strobe, read data one
    // cycle before busy drops.
    bit          m_rd;
    logic [16:0] m_a;
    int          m_bl;
    always begin
        @(posedge clk); #2;
        if (mdl_auto && (!sdram_rd_n || !sdram_wr_n)) begin
            m_rd = !sdram_rd_n;
            m_a  = sdram_address;
            m_bl = mdl_blen;
            mdl_busy = 1'b1;
            for (int k = 0; k < m_bl; k++) begin
                @(posedge clk); #2;
                mdl_rden = m_rd && (k == m_bl - 2);
                if (mdl_rden) mdl_rdata = mdl_fixed ? mdl_data : fn(m_a);
            end
            @(posedge clk); #2;
            mdl_busy = 1'b0;
            mdl_rden = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int p, input bit r, input bit w,
                             input logic [16:0] a, input logic [7:0] d);
        if (p == 0) begin
            p0_req = r; p0_wr = w; p0_address = a; p0_wdata = d;
        end else begin
            p1_req = r; p1_wr = w; p1_address = a; p1_wdata = d;
        end
    endtask

    task automatic wait_ack(output int p);
        p = -1;
        for (int n = 0; n < 40; n++) begin
            tick;
            if (p0_ack) begin p = 0; break; end
            if (p1_ack) begin p = 1; break; end
        end
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, "_rd_n"}, sdram_rd_n, 1);
        chk({t, "_wr_n"}, sdram_wr_n, 1);
        chk({t, "_addr"}, sdram_address, 0);
        chk({t, "_wdata"}, sdram_wdata, 0);
        chk({t, "_ack"}, {p1_ack, p0_ack}, 0);
        chk({t, "_rden"}, {p1_rdata_en, p0_rdata_en}, 0);
        chk({t, "_rdata"}, {p1_rdata, p0_rdata}, 0);
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [15:0] mrd;
        int          blen;
        bit          e_rd_n;
        bit          e_wr_n;
        logic [1:0]  e_rden;
        logic [15:0] e_rdata;
    } vec_t;
    vec_t vt[5];

    task automatic run_vec(input int i, input vec_t v);
        int          p;
        logic [1:0]  seen;
        logic [15:0] d;
        mdl_fixed = 1'b1; mdl_data = v.mrd; mdl_blen = v.blen;
        drive_req(v.port, 1'b1, v.wr, v.addr, v.wdata);
        wait_ack(p);
        chk($sformatf("v%0d_ack_port", i), p, v.port);
        chk($sformatf("v%0d_rd_n", i), sdram_rd_n, v.e_rd_n);
        chk($sformatf("v%0d_wr_n", i), sdram_wr_n, v.e_wr_n);
        chk($sformatf("v%0d_addr", i), sdram_address, v.addr);
        chk($sformatf("v%0d_wdata", i), sdram_wdata, v.wdata);
        drive_req(v.port, 1'b0, v.wr, v.addr, v.wdata);
        ref_last = v.port;
        seen = 2'b00; d = '0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (n == 0) chk($sformatf("v%0d_strobe_hi", i), {sdram_rd_n, sdram_wr_n}, 2'b11);
            if (p0_rdata_en) begin seen[0] = 1'b1; d = p0_rdata; end
            if (p1_rdata_en) begin seen[1] = 1'b1; d = p1_rdata; end
        end
        chk($sformatf("v%0d_rden", i), seen, v.e_rden);
        if (v.e_rden != 2'b00) chk($sformatf("v%0d_rdata", i), d, v.e_rdata);
    endtask

    // Transaction-level reference for random traffic.
    bit          act[2], wr_r[2], pend[2];
    logic [16:0] ad_r[2];
    logic [7:0]  wd_r[2];
    logic [15:0] exp_d[2];

    task automatic rnd_step(input bit allow_new);
        bit a[2];
        bit en;
        logic [15:0] rd;
        int exp_p;
        a[0] = p0_ack; a[1] = p1_ack;
        chk("r_strobe_vs_ack", !sdram_rd_n || !sdram_wr_n, a[0] || a[1]);
        for (int p = 0; p < 2; p++) begin
            if (a[p]) begin
                exp_p = (act[0] && act[1]) ? (RR ? int'(!ref_last) : 0) : p;
                chk("r_req_live", act[p], 1);
                chk("r_owner", p, exp_p);
                chk("r_rd_n", sdram_rd_n, wr_r[p]);
                chk("r_wr_n", sdram_wr_n, !wr_r[p]);
                chk("r_addr", sdram_address, ad_r[p]);
                if (wr_r[p]) chk("r_wdata", sdram_wdata, wd_r[p]);
                if (!wr_r[p]) begin pend[p] = 1'b1; exp_d[p] = fn(ad_r[p]); end
                act[p] = 1'b0;
                ref_last = p[0];
            end
        end
        for (int p = 0; p < 2; p++) begin
            en = (p == 0) ? p0_rdata_en : p1_rdata_en;
            rd = (p == 0) ? p0_rdata : p1_rdata;
            if (en) begin
                chk("r_rden_expected", pend[p], 1);
                chk("r_rdata", rd, exp_d[p]);
                pend[p] = 1'b0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (!act[p] && allow_new && $urandom_range(0, 2) == 0) begin
                act[p]  = 1'b1;
                wr_r[p] = 1'($urandom_range(0, 1));
                ad_r[p] = 17'($urandom_range(0, 32'h1FFFF));
                wd_r[p] = 8'($urandom_range(0, 255));
            end
            drive_req(p, act[p], wr_r[p], ad_r[p], wd_r[p]);
        end
        mdl_blen = $urandom_range(2, 6);
    endtask

    initial begin
        int          p, nb;
        bit          bad;
        logic [1:0]  seen;
        logic [15:0] d;

        vt[0] = '{1'b1, 1'b1, 17'h1ABCD, 8'h5A, 16'h0000, 5, 1'b1, 1'b0, 2'b00, 16'h0000};
        vt[1] = '{1'b0, 1'b0, 17'h00040, 8'h00, 16'hBEEF, 3, 1'b0, 1'b1, 2'b01, 16'hBEEF};
        vt[2] = '{1'b1, 1'b0, 17'h1FFFF, 8'h00, 16'h0001, 2, 1'b0, 1'b1, 2'b10, 16'h0001};
        vt[3] = '{1'b0, 1'b1, 17'h00000, 8'hFF, 16'h0000, 2, 1'b1, 1'b0, 2'b00, 16'h0000};
        vt[4] = '{1'b1, 1'b0, 17'h10000, 8'h00, 16'hFFFF, 6, 1'b0, 1'b1, 2'b10, 16'hFFFF};

        n_reset = 1'b0;
        drive_req(0, 0, 0, '0, '0);
        drive_req(1, 0, 0, '0, '0);
        man_busy = 1'b1; man_rden = 1'b0; man_rdata = '0;
        ref_last = 1'b1;
        repeat (3) tick;
        chk_reset_vals("rst");
        n_reset = 1'b1;

        // Initialisation: busy held high blocks any grant.
        drive_req(0, 1, 0, 17'h00123, 8'h00);
        bad = 1'b0;
        repeat (20) begin
            tick;
            if (p0_ack || p1_ack || !sdram_rd_n || !sdram_wr_n) bad = 1'b1;
        end
        chk("init_no_ack", bad, 0);
        man_busy = 1'b0;
        wait_ack(p);
        chk("init_ack_port", p, 0);
        chk("init_rd_n_low", sdram_rd_n, 0);
        chk("init_addr", sdram_address, 17'h00123);
        drive_req(0, 0, 0, 17'h00123, 8'h00);
        ref_last = 1'b0;
        tick;
        chk("init_rd_n_1cyc", sdram_rd_n, 1);
        chk("init_ack_1cyc", p0_ack, 0);
        man_busy = 1'b1;
        tick; tick;
        man_rden = 1'b1; man_rdata = 16'h1234;
        tick;
        man_rden = 1'b0; man_busy = 1'b0;
        chk("init_rden", {p1_rdata_en, p0_rdata_en}, 2'b01);
        chk("init_rdata", p0_rdata, 16'h1234);
        tick;
        chk("init_rden_pulse", p0_rdata_en, 0);
        repeat (3) tick;

        // Vector table with the auto model.
        mdl_auto = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

        // A request queued behind a write is accepted the cycle after busy drops.
        mdl_fixed = 1'b0; mdl_blen = 5;
        drive_req(1, 1, 1, 17'h1ABCD, 8'h5A);
        wait_ack(p);
        chk("b2b_first_port", p, 1);
        drive_req(1, 0, 1, 17'h1ABCD, 8'h5A);
        ref_last = 1'b1;
        drive_req(0, 1, 0, 17'h00055, 8'h00);
        nb = 0; bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (p0_ack) bad = 1'b1;
            if (sdram_busy) nb++;
            else if (nb > 0) break;
        end
        chk("b2b_no_early_ack", bad, 0);
        tick;
        chk("b2b_ack", p0_ack, 1);
        chk("b2b_rd_n", sdram_rd_n, 0);
        drive_req(0, 0, 0, 17'h00055, 8'h00);
        ref_last = 1'b0;
        seen = '0; d = '0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (p0_rdata_en) begin seen[0] = 1'b1; d = p0_rdata; end
            if (p1_rdata_en) seen[1] = 1'b1;
        end
        chk("b2b_rden", seen, 2'b01);
        chk("b2b_rdata", d, fn(17'h00055));

        // Both ports requesting continuously.
        mdl_blen = 2;
        drive_req(0, 1, 1, 17'h00AAA, 8'h11);
        drive_req(1, 1, 1, 17'h00BBB, 8'h22);
        for (int g = 0; g < 8; g++) begin
            wait_ack(p);
            chk($sformatf("fair_g%0d", g), p, RR ? int'(!ref_last) : 0);
            ref_last = p[0];
        end
        drive_req(0, 0, 1, 17'h00AAA, 8'h11);
        drive_req(1, 0, 1, 17'h00BBB, 8'h22);
        repeat (15) tick;

        // Reset in the middle of a read with data pending.
        mdl_auto = 1'b0; man_busy = 1'b0;
        drive_req(0, 1, 0, 17'h00077, 8'h00);
        wait_ack(p);
        chk("mrst_ack", p, 0);
        drive_req(0, 0, 0, 17'h00077, 8'h00);
        man_busy = 1'b1;
        tick; tick;
        man_rden = 1'b1; man_rdata = 16'hDEAD;
        #2 n_reset = 1'b0;
        #1 chk_reset_vals("mrst");
        tick;
        man_rden = 1'b0; man_busy = 1'b0;
        tick;
        n_reset = 1'b1; ref_last = 1'b1;
        seen = '0;
        repeat (4) begin
            tick;
            seen = seen | {p1_rdata_en, p0_rdata_en};
        end
        chk("mrst_no_rden", seen, 0);
        chk("mrst_rdata_clr", p0_rdata, 0);
        mdl_auto = 1'b1;
        run_vec(5, vt[1]);

        // Spurious read data in IDLE and during a write.
        mdl_auto = 1'b0;
        man_rden = 1'b1; man_rdata = 16'hAAAA;
        tick;
        man_rden = 1'b0;
        seen = '0;
        repeat (3) begin tick; seen = seen | {p1_rdata_en, p0_rdata_en}; end
        chk("spur_idle_rden", seen, 0);
        chk("spur_idle_p0_rdata", p0_rdata, 16'hBEEF);
        chk("spur_idle_p1_rdata", p1_rdata, 16'h0000);
        drive_req(1, 1, 1, 17'h00F0F, 8'h3C);
        wait_ack(p);
        chk("spur_wr_ack", p, 1);
        drive_req(1, 0, 1, 17'h00F0F, 8'h3C);
        ref_last = 1'b1;
        man_busy = 1'b1;
        tick; tick;
        man_rden = 1'b1; man_rdata = 16'h5555;
        tick;
        man_rden = 1'b0; man_busy = 1'b0;
        seen = '0;
        repeat (4) begin tick; seen = seen | {p1_rdata_en, p0_rdata_en}; end
        chk("spur_wr_rden", seen, 0);
        chk("spur_wr_p1_rdata", p1_rdata, 16'h0000);

        // Random traffic against the reference.
        mdl_auto = 1'b1; mdl_fixed = 1'b0;
        for (int p2 = 0; p2 < 2; p2++) begin act[p2] = 0; pend[p2] = 0; end
        for (int c = 0; c < 1600; c++) begin
            tick;
            rnd_step(c < 1450);
        end
        chk("r_drain", {act[0], act[1], pend[0], pend[1]}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
